int_to_fp_seq: RTL and testbench

Parametrised, handshaked integer-to-floating-point converter; the successor to the team's combinational 8-bit converter. It accepts a sign-magnitude or two's-complement integer and normalises it serially, one shift per clock. It can round to nearest-even when the fraction is narrower than the magnitude. It sits between integer datapath sources and the fp adder/multiplier blocks. The output format is {sign, exp, frac}, with value = 0.frac × 2^exp and frac MSB = 1 when non-zero.

---
 rtl/int_to_fp_pkg.sv | 26 ++
 rtl/int_to_fp_seq_fp_round.sv | 67 ++++++
 rtl/int_to_fp_seq.sv | 171 +++++++++++++++++
 tb/tb_int_to_fp_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_to_fp_pkg.sv
// -----------------------------------------------------------------------------
// int_to_fp_pkg
// Shared types and helpers for the serial integer-to-floating-point converter
// and for the floating-point blocks that reuse its rounding stage.
//   state_e : converter control states
//   out_w() : packed result width {sign, exp, frac}
//   RND_*   : encodings of the rnd_mode input
// -----------------------------------------------------------------------------
package int_to_fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  // Width of the packed {sign, exp, frac} result word.
  function automatic int out_w(input int exp_w, input int frac_w);
    return 32'sd1 + exp_w + frac_w;
  endfunction

endpackage

// File: rtl/int_to_fp_seq_fp_round.sv
// -----------------------------------------------------------------------------
// fp_round
// Combinational rounding / exponent-saturation stage. Expects a normalised
// magnitude (MSB set) and produces the fraction, exponent and overflow flag.
// Also used by the fp adder normaliser, so it carries no state.
//   mag_i      : normalised magnitude, INT_W bits
//   exp_cnt_i  : unbiased exponent before rounding
//   rnd_mode_i : RND_TRUNC or RND_RNE
//   exp_o      : exponent, saturated to all ones on overflow
//   frac_o     : fraction, all ones on overflow
//   ovf_o      : exponent did not fit in EXP_W bits
// -----------------------------------------------------------------------------
module fp_round
  import int_to_fp_pkg::*;
#(
  parameter int INT_W  = 8,
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8,
  parameter int CNT_W  = $clog2(INT_W + 2)
) (
  input  logic [INT_W-1:0]  mag_i,
  input  logic [CNT_W-1:0]  exp_cnt_i,
  input  logic              rnd_mode_i,
  output logic [EXP_W-1:0]  exp_o,
  output logic [FRAC_W-1:0] frac_o,
  output logic              ovf_o
);

  localparam int          EXT_W   = INT_W + FRAC_W;
  localparam logic [31:0] EXP_MAX = (32'd1 << EXP_W) - 32'd1;

  // Magnitude followed by FRAC_W zeros: the top FRAC_W bits are the truncated
  // fraction whether or not the fraction is wider than the magnitude, and the
  // guard/sticky positions fall into the zero padding when it is wider.
  logic [EXT_W-1:0]  ext_s;
  logic [FRAC_W-1:0] frac_trunc_s;
  logic              guard_s;
  logic              sticky_s;
  logic              inc_s;
  logic [FRAC_W:0]   frac_sum_s;
  logic [31:0]       exp_wide_s;

  assign ext_s        = {mag_i, {FRAC_W{1'b0}}};
  assign frac_trunc_s = ext_s[EXT_W-1 -: FRAC_W];
  assign guard_s      = ext_s[INT_W-1];
  assign sticky_s     = |ext_s[INT_W-2:0];

  // Round-nearest-even increment, carry renormalisation and saturation.
  always_comb begin
    inc_s      = (rnd_mode_i == RND_RNE) & guard_s & (sticky_s | frac_trunc_s[0]);
    frac_sum_s = {1'b0, frac_trunc_s} + {{FRAC_W{1'b0}}, inc_s};
    exp_wide_s = 32'(exp_cnt_i) + {31'd0, frac_sum_s[FRAC_W]};
    ovf_o      = (exp_wide_s > EXP_MAX);
    if (ovf_o) begin
      exp_o  = {EXP_W{1'b1}};
      frac_o = {FRAC_W{1'b1}};
    end else if (frac_sum_s[FRAC_W]) begin
      // Carry out of the fraction: 0.11..1 + ulp = 1.0 -> 0.10..0 x 2^(e+1)
      exp_o  = exp_wide_s[EXP_W-1:0];
      frac_o = FRAC_W'(1'b1) << (FRAC_W - 1);
    end else begin
      exp_o  = exp_wide_s[EXP_W-1:0];
      frac_o = frac_sum_s[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/int_to_fp_seq.sv
// -----------------------------------------------------------------------------
// int_to_fp_seq
// Handshaked integer-to-floating-point converter. The operand magnitude is
// normalised one left shift per clock, then rounded in a single cycle.
// Result format {sign, exp, frac}, value = 0.frac x 2^exp, frac MSB set
// for non-zero results. One conversion in flight.
//   clk_i, rst_ni : clock and synchronous active-low reset
//   in_valid_i / in_ready_o / in_int_i / rnd_mode_i : operand channel
//   out_valid_o / out_ready_i / out_fp_o / out_ovf_o : result channel
// -----------------------------------------------------------------------------
module int_to_fp_seq
  import int_to_fp_pkg::*;
#(
  parameter  int INT_W  = 8,
  parameter  int EXP_W  = 4,
  parameter  int FRAC_W = 8,
  parameter  int TWOS   = 0,
  localparam int OUT_W  = out_w(EXP_W, FRAC_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [INT_W-1:0] in_int_i,
  input  logic             rnd_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_fp_o,
  output logic             out_ovf_o
);

  localparam int CNT_W = $clog2(INT_W + 2);

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [INT_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   exp_cnt_q, exp_cnt_d;
  logic               rnd_q, rnd_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_fp_q, out_fp_d;
  logic               out_ovf_q, out_ovf_d;

  logic [INT_W-1:0]   in_mag_s;
  logic               zero_sign_s;
  logic [EXP_W-1:0]   rnd_exp_s;
  logic [FRAC_W-1:0]  rnd_frac_s;
  logic               rnd_ovf_s;

  // Operand magnitude; in two's complement the most negative value maps to
  // 100..0, which still fits the unsigned INT_W-bit magnitude.
  always_comb begin
    if (TWOS != 0) begin
      if (in_int_i[INT_W-1]) begin
        in_mag_s = (~in_int_i) + INT_W'(1'b1);
      end else begin
        in_mag_s = in_int_i;
      end
    end else begin
      in_mag_s = {1'b0, in_int_i[INT_W-2:0]};
    end
  end

  // Two's complement has a single zero; sign-magnitude keeps -0.
  assign zero_sign_s = (TWOS != 0) ? 1'b0 : sign_q;

  fp_round #(
    .INT_W  (INT_W),
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W),
    .CNT_W  (CNT_W)
  ) u_round (
    .mag_i      (mag_q),
    .exp_cnt_i  (exp_cnt_q),
    .rnd_mode_i (rnd_q),
    .exp_o      (rnd_exp_s),
    .frac_o     (rnd_frac_s),
    .ovf_o      (rnd_ovf_s)
  );

  // Next-state and next-output logic of the control FSM.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_cnt_d   = exp_cnt_q;
    rnd_d       = rnd_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_fp_d    = out_fp_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          sign_d     = in_int_i[INT_W-1];
          mag_d      = in_mag_s;
          exp_cnt_d  = CNT_W'(INT_W);
          rnd_d      = rnd_mode_i;
          in_ready_d = 1'b0;
          state_d    = ST_NORM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NORM: begin
        if (mag_q == {INT_W{1'b0}}) begin
          out_fp_d    = {zero_sign_s, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
          out_ovf_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (mag_q[INT_W-1]) begin
          state_d = ST_ROUND;
        end else begin
          mag_d     = {mag_q[INT_W-2:0], 1'b0};
          exp_cnt_d = exp_cnt_q - CNT_W'(1'b1);
        end
      end
      ST_ROUND: begin
        out_fp_d    = {sign_q, rnd_exp_s, rnd_frac_s};
        out_ovf_d   = rnd_ovf_s;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      mag_q       <= {INT_W{1'b0}};
      exp_cnt_q   <= {CNT_W{1'b0}};
      rnd_q       <= RND_TRUNC;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_fp_q    <= {OUT_W{1'b0}};
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_cnt_q   <= exp_cnt_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_fp_q    <= out_fp_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_fp_o    = out_fp_q;
  assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// -----------------------------------------------------------------------------
// tb_int_to_fp_seq
// Four converter configurations run side by side:
//   g0: INT_W=8,  FRAC_W=8, sign-magnitude
//   g1: INT_W=8,  FRAC_W=8, two's complement
//   g2: INT_W=12, FRAC_W=4, sign-magnitude (rounding active)
//   g3: INT_W=16, FRAC_W=8, two's complement (exponent overflow)
// Each has its own stimulus process pushing reference results into a queue
// and a monitor process that pops and compares whenever a result is offered.
// -----------------------------------------------------------------------------
module tb_int_to_fp_seq;

  localparam int NDUT = 4;
  localparam int EW   = 4;

  typedef struct {
    longint fp;
    bit     ovf;
    int     lat;
    int     acc;
    bit     hold;
  } exp_t;

  logic clk;
  int   cyc;
  int   n_applied;
  int   miscompares;
  int   n_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int IW = (g == 2) ? 12 : ((g == 3) ? 16 : 8);
    localparam int FW = (g == 2) ? 4 : 8;
    localparam int TW = (g == 1 || g == 3) ? 1 : 0;
    localparam int OW = 1 + EW + FW;

    logic          rst_n, in_valid, in_ready, rnd, out_valid, out_ready, out_ovf;
    logic [IW-1:0] in_int;
    logic [OW-1:0] out_fp;
    exp_t          q[$];

    int_to_fp_seq #(.INT_W(IW), .EXP_W(EW), .FRAC_W(FW), .TWOS(TW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_int_i    (in_int),
      .rnd_mode_i  (rnd),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_fp_o    (out_fp),
      .out_ovf_o   (out_ovf)
    );

    // Reference: value-level conversion. e = number of significant bits,
    // frac = m * 2^FW / 2^e with remainder-based nearest-even rounding.
    task automatic ref_conv(input longint v, input bit r,
                            output longint fp, output bit ovf, output int lat);
      longint m, f, rem, scale, one_e;
      int     e;
      bit     s;
      s = ((v >> (IW - 1)) & 64'd1) != 64'd0;
      if (TW != 0) m = s ? ((longint'(1) << IW) - v) : v;
      else         m = v & ((longint'(1) << (IW - 1)) - 1);
      ovf = 1'b0;
      lat = 0;
      if (m == 0) begin
        fp = (TW == 0 && s) ? (longint'(1) << (EW + FW)) : 64'd0;
      end else begin
        e = 0;
        while ((longint'(1) << e) <= m) e++;
        lat   = IW - e + 3;
        one_e = longint'(1) << e;
        scale = m << FW;
        f     = scale / one_e;
        rem   = scale - f * one_e;
        if (r && ((2 * rem > one_e) || (2 * rem == one_e && (f % 2) == 1))) f++;
        if (f == (longint'(1) << FW)) begin
          f = longint'(1) << (FW - 1);
          e++;
        end
        if (e > (1 << EW) - 1) begin
          ovf = 1'b1;
          e   = (1 << EW) - 1;
          f   = (longint'(1) << FW) - 1;
        end
        fp = (longint'(s) << (EW + FW)) | (longint'(e) << FW) | f;
      end
    endtask

    // Offer one operand (called at a negedge), hold it until accepted.
    task automatic issue(input longint v, input bit r, input bit hold,
                         input bit use_c, input longint c_fp, input bit c_ovf);
      exp_t   e;
      longint fp;
      bit     ovf;
      int     lat;
      int     w;
      ref_conv(v, r, fp, ovf, lat);
      e.fp   = use_c ? c_fp : fp;
      e.ovf  = use_c ? c_ovf : ovf;
      e.lat  = lat;
      e.hold = hold;
      in_valid = 1'b1;
      in_int   = IW'(v);
      rnd      = r;
      w = 0;
      while (in_ready !== 1'b1 && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (w >= 300) begin
        miscompares++;
        $display("FAIL g%0d_accept_timeout: in_ready=%b, expected 1", g, in_ready);
      end else begin
        e.acc = cyc;
        q.push_back(e);
        n_applied++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_int   = IW'($urandom);
      rnd      = 1'($urandom);
    endtask

    task automatic drain();
      for (int w = 0; w < 300 && q.size() != 0; w++) @(negedge clk);
      if (q.size() != 0) begin
        miscompares++;
        $display("FAIL g%0d_drain_timeout: %0d results pending, expected 0", g, q.size());
      end
    endtask

    // Stimulus
    initial begin
      longint v, mask;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_int   = '0;
      rnd      = 1'b0;
      mask     = (longint'(1) << IW) - 1;
      repeat (2) @(negedge clk);
      chk($sformatf("g%0d_rst_in_ready", g), longint'(in_ready), 64'd1);
      chk($sformatf("g%0d_rst_out_valid", g), longint'(out_valid), 64'd0);
      chk($sformatf("g%0d_rst_out_fp", g), longint'(out_fp), 64'd0);
      chk($sformatf("g%0d_rst_out_ovf", g), longint'(out_ovf), 64'd0);
      rst_n = 1'b1;
      case (g)
        0: begin
          issue(64'h0F, 1'b0, 1'b0, 1'b1, 64'h04F0, 1'b0);
          issue(64'h85, 1'b0, 1'b0, 1'b1, 64'h13A0, 1'b0);
          issue(64'h00, 1'b0, 1'b0, 1'b1, 64'h0000, 1'b0);
          issue(64'h80, 1'b0, 1'b0, 1'b1, 64'h1000, 1'b0);
          issue(64'h0F, 1'b0, 1'b1, 1'b1, 64'h04F0, 1'b0);
          issue(64'h85, 1'b1, 1'b0, 1'b1, 64'h13A0, 1'b0);
        end
        1: begin
          issue(64'h80, 1'b0, 1'b0, 1'b1, 64'h1880, 1'b0);
          issue(64'hFF, 1'b0, 1'b0, 1'b1, 64'h1180, 1'b0);
        end
        2: begin
          issue(64'h0F8, 1'b1, 1'b0, 1'b1, 64'h098, 1'b0);
          issue(64'h0F8, 1'b0, 1'b0, 1'b1, 64'h08F, 1'b0);
          issue(64'h0E8, 1'b1, 1'b0, 1'b1, 64'h08E, 1'b0);
        end
        default: begin
          issue(64'h8000, 1'b0, 1'b0, 1'b1, 64'h1FFF, 1'b1);
          issue(64'h4000, 1'b0, 1'b0, 1'b1, 64'h0F80, 1'b0);
        end
      endcase
      for (int i = 0; i < 30; i++) begin
        case ($urandom_range(0, 5))
          0:       v = 64'd0;
          1:       v = longint'(1) << (IW - 1);
          2:       v = mask;
          3:       v = longint'($urandom_range(0, 15));
          default: v = longint'($urandom) & mask;
        endcase
        issue(v, 1'($urandom), ($urandom_range(0, 7) == 0), 1'b0, 64'd0, 1'b0);
      end
      drain();

      // Abort a long conversion with reset; no result may appear afterwards.
      in_valid = 1'b1;
      in_int   = IW'(1);
      rnd      = 1'b0;
      for (int w = 0; w < 300 && in_ready !== 1'b1; w++) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk($sformatf("g%0d_abort_out_valid", g), longint'(out_valid), 64'd0);
      chk($sformatf("g%0d_abort_in_ready", g), longint'(in_ready), 64'd1);
      rst_n = 1'b1;
      repeat (IW + 6) @(negedge clk);
      issue(64'd3, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
      drain();
      n_done++;
    end

    // Monitor / scoreboard
    initial begin
      exp_t cur;
      bit   seen, unexp;
      int   hold_left;
      seen      = 1'b0;
      unexp     = 1'b0;
      hold_left = 0;
      out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          chk($sformatf("g%0d_busy_in_ready", g), longint'(in_ready), 64'd0);
          if (!seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
              unexp = 1'b1;
              miscompares++;
              $display("FAIL g%0d_unexpected_out: got %0h, expected no output", g, out_fp);
            end else begin
              cur = q[0];
              if (cur.lat > 0)
                chk($sformatf("g%0d_latency", g), longint'(cyc - cur.acc), longint'(cur.lat));
              hold_left = cur.hold ? 5 : 0;
            end
          end
          if (!unexp) begin
            chk($sformatf("g%0d_out_fp", g), longint'(out_fp), cur.fp);
            chk($sformatf("g%0d_out_ovf", g), longint'(out_ovf), longint'(cur.ovf));
          end
        end
        if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (out_valid === 1'b1 && out_ready) begin
          if (!unexp) void'(q.pop_front());
          seen  = 1'b0;
          unexp = 1'b0;
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < 60000 && n_done < NDUT; c++) @(posedge clk);
    if (n_done < NDUT) begin
      miscompares++;
      $display("FAIL timeout: %0d configurations finished, expected %0d", n_done, NDUT);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, miscompares);
    $finish;
  end

endmodule
